// File: rtl/wave_shaper.sv
// rtl/wave_shaper.sv - phase-to-waveform shaper (triangle/saw/square/mute) with gain, offset and clip
// Optional clip-event counter: define WAVE_SAT_CNT_EN.
module wave_shaper #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int AMP_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PHASE_W-1:0]       phase_in,
    input  logic                     phase_valid,
    input  logic [1:0]               mode,
    input  logic [AMP_W-1:0]         amp,
    input  logic signed [OUT_W-1:0]  offset,
    output logic signed [OUT_W-1:0]  wave_out,
    output logic                     wave_valid,
    output logic [15:0]              sat_count
);

    localparam int N  = OUT_W;
    localparam int PW = N + AMP_W + 1;
    localparam int SW = PW + 1;

    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINP = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] NEG_MAXP = MINP + 1'b1;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (AMP_W - 2));
    localparam logic signed [SW-1:0] MAXS = $signed({{(SW-N){1'b0}}, MAXP});
    localparam logic signed [SW-1:0] MINS = $signed({{(SW-N){1'b1}}, MINP});

    typedef enum logic [1:0] {
        WAVE_TRI  = 2'd0,
        WAVE_SAW  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_MUTE = 2'd3
    } wave_mode_t;

    wave_mode_t active_mode;
    wave_mode_t eff_mode;
    logic       prev_msb;
    logic       armed;
    logic       load_mode;

    logic [N-1:0] p;
    logic [N-2:0] t;
    logic [N-1:0] shape;

    logic                   s1_valid;
    logic signed [N-1:0]    s1_shape;
    logic                   s2_valid;
    logic signed [PW-1:0]   s2_prod;

    logic signed [SW-1:0] rnd_sum;
    logic signed [SW-1:0] scaled;
    logic signed [SW-1:0] sum;
    logic [N-1:0]         clipped_val;

    assign p = phase_in[PHASE_W-1 -: N];

    generate
        if (PHASE_W > OUT_W) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^phase_in[PHASE_W-N-1:0];
        end
    endgenerate

    // A new mode is adopted on the first sample after reset, then only on the wrap sample.
    assign load_mode = phase_valid & (~armed | (prev_msb & ~p[N-1]));
    assign eff_mode  = load_mode ? wave_mode_t'(mode) : active_mode;
    assign t         = p[N-1] ? ~p[N-2:0] : p[N-2:0];

    always_comb begin
        shape = '0;
        case (eff_mode)
            WAVE_TRI:  shape = {t, 1'b0} - MINP;
            WAVE_SAW:  shape = {~p[N-1], p[N-2:0]};
            WAVE_SQR:  shape = p[N-1] ? NEG_MAXP : MAXP;
            WAVE_MUTE: shape = '0;
            default:   shape = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode <= WAVE_TRI;
            prev_msb    <= 1'b0;
            armed       <= 1'b0;
        end else if (phase_valid) begin
            armed    <= 1'b1;
            prev_msb <= p[N-1];
            if (load_mode) begin
                active_mode <= wave_mode_t'(mode);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_shape <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s1_valid <= phase_valid;
            if (phase_valid) begin
                s1_shape <= shape;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= s1_shape * $signed({1'b0, amp});
            end
        end
    end

    // Round half up, then add offset with enough headroom that the clip sees the true sum.
    always_comb begin
        rnd_sum     = $signed({s2_prod[PW-1], s2_prod}) + RND;
        scaled      = rnd_sum >>> (AMP_W - 1);
        sum         = scaled + $signed({{(SW-N){offset[N-1]}}, offset});
        clipped_val = sum[N-1:0];
        if (sum > MAXS) begin
            clipped_val = MAXP;
        end else if (sum < MINS) begin
            clipped_val = MINP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_out   <= '0;
            wave_valid <= 1'b0;
        end else begin
            wave_valid <= s2_valid;
            if (s2_valid) begin
                wave_out <= clipped_val;
            end
        end
    end

`ifdef WAVE_SAT_CNT_EN
    logic [15:0] sat_r;
    logic        sat_hit;

    assign sat_hit = s2_valid && ((sum > MAXS) || (sum < MINS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= '0;
        end else if (sat_hit && (sat_r != 16'hFFFF)) begin
            sat_r <= sat_r + 16'd1;
        end
    end

    assign sat_count = sat_r;
`else
    assign sat_count = '0;
`endif

endmodule
